// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the dmem side of dmem_arbiter.
//   Requester N (N = 0 CPU, 1 loader/debug):
//     reqN, weN, lockN, addrN[AW], wdataN[DW]  -> arbiter
//     gntN, rvalidN, rdataN[DW]                 <- arbiter
//   Memory side:
//     mem_we, mem_addr[AW], mem_wdata[DW]       <- arbiter
//     mem_rdata[DW]                             -> arbiter (combinational read)
//   Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port dmem between the CPU data port (port 0) and a
//   secondary requester (port 1). At most one access is granted per cycle;
//   grants are combinational, read data returns registered one cycle after
//   the grant edge. Locked bursts hold ownership for at most LOCK_MAX grants.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high
//     bus    - dmem_arbiter_if.slave (requester handshakes + dmem side)
//   Parameters: AW address width, DW data width, LOCK_MAX (>=1) max
//   consecutive locked grants.
//   Build option: define DMEM_ARB_RR_EN for a round-robin tie policy in FREE;
//   otherwise port 0 wins ties.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int            CW        = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d, cnt_inc;
    logic          last_gnt_q, last_gnt_d;
    // One-cycle override after a forced release: pref_q names the port that
    // wins a tie in the cycle right after the release.
    logic          pref_vld_q, pref_vld_d;
    logic          pref_q, pref_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          gnt0, gnt1, win1;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;

    // Grant decision.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        win1 = 1'b0;
        case (state_q)
            FREE: begin
                if (bus.req0 && bus.req1) begin
                    if (pref_vld_q) begin
                        win1 = pref_q;
                    end else begin
`ifdef DMEM_ARB_RR_EN
                        win1 = ~last_gnt_q;
`else
                        win1 = 1'b0;
`endif
                    end
                    gnt0 = ~win1;
                    gnt1 = win1;
                end else begin
                    gnt0 = bus.req0;
                    gnt1 = bus.req1;
                end
            end
            OWN0:    gnt0 = bus.req0;
            OWN1:    gnt1 = bus.req1;
            default: ;
        endcase
    end

    // Ownership, lock counter and tie-breaking history.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_gnt_d = last_gnt_q;
        pref_vld_d = 1'b0;
        pref_d     = pref_q;
        cnt_inc    = lock_cnt_q + CW'(1);

        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end

        case (state_q)
            FREE: begin
                lock_cnt_d = '0;
                if ((gnt0 && bus.lock0) || (gnt1 && bus.lock1)) begin
                    // With LOCK_MAX of 1 the entering grant already exhausts
                    // the burst, so it is a forced release straight away.
                    if (LOCK_MAX == 1) begin
                        pref_vld_d = 1'b1;
                        pref_d     = gnt0;
                    end else begin
                        state_d    = gnt0 ? OWN0 : OWN1;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            OWN0: begin
                if (!(bus.req0 && bus.lock0)) begin
                    state_d    = FREE;
                    lock_cnt_d = '0;
                end else if (cnt_inc == LOCK_LAST) begin
                    state_d    = FREE;
                    lock_cnt_d = '0;
                    pref_vld_d = 1'b1;
                    pref_d     = 1'b1;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            OWN1: begin
                if (!(bus.req1 && bus.lock1)) begin
                    state_d    = FREE;
                    lock_cnt_d = '0;
                end else if (cnt_inc == LOCK_LAST) begin
                    state_d    = FREE;
                    lock_cnt_d = '0;
                    pref_vld_d = 1'b1;
                    pref_d     = 1'b0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d    = FREE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Memory mux and read-data capture.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt0) begin
            mem_we_c    = bus.we0;
            mem_addr_c  = bus.addr0;
            mem_wdata_c = bus.wdata0;
        end else if (gnt1) begin
            mem_we_c    = bus.we1;
            mem_addr_c  = bus.addr1;
            mem_wdata_c = bus.wdata1;
        end

        rvalid0_d = gnt0 && !bus.we0;
        rvalid1_d = gnt1 && !bus.we1;
        rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FREE;
            lock_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            pref_vld_q <= 1'b0;
            pref_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_gnt_q <= last_gnt_d;
            pref_vld_q <= pref_vld_d;
            pref_q     <= pref_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Scoreboard bench for dmem_arbiter: a driver process issues directed and
//   random handshakes, predicts grants and memory-side values from an
//   ownership model, and queues expected read responses; a monitor process
//   pops and checks them when rvalid appears. Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural dmem driven by the arbiter's memory port.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int clear_at    = -1;
    rd_t rq0[$];
    rd_t rq1[$];
    logic [DW-1:0] hold[2];

    // Requester stimulus
    logic          s_req[2], s_we[2], s_lock[2];
    logic [AW-1:0] s_addr[2];
    logic [DW-1:0] s_wdata[2];

    // Reference model: owner -1 = nobody, pref -1 = no override
    int m_owner, m_cnt, m_last, m_pref;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_pref  = -1;
    endtask

    function automatic int model_grant();
        if (m_owner == 0) return s_req[0] ? 0 : -1;
        if (m_owner == 1) return s_req[1] ? 1 : -1;
        if (s_req[0] && s_req[1]) begin
            if (m_pref >= 0) return m_pref;
            return RR ? 1 - m_last : 0;
        end
        if (s_req[0]) return 0;
        if (s_req[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge(input int g);
        int pref_new;
        int n;
        pref_new = -1;
        if (g >= 0) m_last = g;
        if (m_owner < 0) begin
            if (g >= 0 && s_lock[g]) begin
                if (LOCK_MAX == 1) pref_new = 1 - g;
                else begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end
        end else begin
            n = m_owner;
            if (g == n) m_cnt++;
            if (!(s_req[n] && s_lock[n])) begin
                m_owner = -1;
                m_cnt   = 0;
            end else if (m_cnt >= LOCK_MAX) begin
                m_owner  = -1;
                m_cnt    = 0;
                pref_new = 1 - n;
            end
        end
        m_pref = pref_new;
    endtask

    task automatic set_port(input int p, input logic rq, input logic we, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_req[p] = rq; s_we[p] = we; s_lock[p] = lk; s_addr[p] = a; s_wdata[p] = d;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock cycle: drive, check combinational outputs, predict, advance.
    task automatic step(output int g);
        rd_t e;
        bus.req0 = s_req[0]; bus.we0 = s_we[0]; bus.lock0 = s_lock[0];
        bus.addr0 = s_addr[0]; bus.wdata0 = s_wdata[0];
        bus.req1 = s_req[1]; bus.we1 = s_we[1]; bus.lock1 = s_lock[1];
        bus.addr1 = s_addr[1]; bus.wdata1 = s_wdata[1];
        #2;
        g = model_grant();
        chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
        if (g >= 0) begin
            chk("mem_we", 32'(bus.mem_we), 32'(s_we[g]));
            chk("mem_addr", 32'(bus.mem_addr), 32'(s_addr[g]));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(s_wdata[g]));
        end else begin
            chk("mem_we_idle", 32'(bus.mem_we), 0);
            chk("mem_addr_idle", 32'(bus.mem_addr), 0);
            chk("mem_wdata_idle", 32'(bus.mem_wdata), 0);
        end
        if (reset) begin
            model_reset();
            clear_at = cyc + 1;
        end else begin
            if (g >= 0) begin
                if (s_we[g]) ref_mem[s_addr[g]] = s_wdata[g];
                else begin
                    e.due  = cyc + 1;
                    e.data = ref_mem[s_addr[g]];
                    if (g == 0) rq0.push_back(e);
                    else        rq1.push_back(e);
                end
            end
            model_edge(g);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_req(input int p);
        logic keep_lock;
        keep_lock = s_req[p] && s_lock[p];
        s_req[p]   = 1'b1;
        s_we[p]    = ($urandom_range(0, 2) == 0);
        s_lock[p]  = keep_lock ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        s_addr[p]  = AW'($urandom_range(0, 31));
        s_wdata[p] = DW'($urandom);
    endtask

    // Monitor: consumes expected read responses when rvalid is due.
    task automatic check_rd(input int p, input logic v, input logic [DW-1:0] d);
        rd_t e;
        bit  have;
        have = 1'b0;
        if (p == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin
            e = rq0.pop_front(); have = 1'b1;
        end
        if (p == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin
            e = rq1.pop_front(); have = 1'b1;
        end
        if (v || have) begin
            chk(p == 0 ? "rvalid0" : "rvalid1", 32'(v), 32'(have));
            if (have) begin
                chk(p == 0 ? "rdata0" : "rdata1", 32'(d), 32'(e.data));
                hold[p] = e.data;
            end
        end else begin
            chk(p == 0 ? "rdata0_hold" : "rdata1_hold", 32'(d), 32'(hold[p]));
        end
    endtask

    initial begin
        hold[0] = '0;
        hold[1] = '0;
        forever begin
            @(negedge clk);
            if (cyc == clear_at) begin
                hold[0] = '0;
                hold[1] = '0;
            end
            if (cyc > 0) begin
                check_rd(0, bus.rvalid0, bus.rdata0);
                check_rd(1, bus.rvalid1, bus.rdata1);
            end
        end
    end

    initial begin
        int  g;
        bit  done[2];
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 37 + 11);
            ref_mem[i] = mem[i];
        end
        mem[16]     = 8'h5A;
        ref_mem[16] = 8'h5A;
        model_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(g);
        step(g);
        reset = 1'b0;

        // Read 0x10 on port 0
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00); step(g);
        idle(); step(g);

        // Port 1 write 0x20 <= 0xC3, then port 0 reads it back
        set_port(1, 1'b1, 1'b1, 1'b0, 8'h20, 8'hC3); step(g);
        idle(); set_port(0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00); step(g);
        idle(); step(g);

        // Tie behaviour from reset: both reading for 4 cycles
        reset = 1'b1; step(g); reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
        repeat (4) step(g);
        idle(); step(g);

        // Port 1 locked burst against a waiting port 0
        set_port(1, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00); step(g);
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
        repeat (9) step(g);
        idle(); step(g);

        // OWN0 with a one-cycle drop of req0 while port 1 waits
        set_port(0, 1'b1, 1'b0, 1'b1, 8'h07, 8'h00); step(g);
        s_req[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00); step(g);
        step(g);
        idle(); step(g);

        // Reset the cycle after a granted read
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00); step(g);
        idle(); reset = 1'b1; step(g);
        reset = 1'b0; step(g);
        step(g);

        // Random traffic obeying the hold-until-grant handshake
        done[0] = 1'b1;
        done[1] = 1'b1;
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!s_req[p] || done[p]) begin
                    if ($urandom_range(0, 9) < 7) new_req(p);
                    else s_req[p] = 1'b0;
                end
            end
            step(g);
            done[0] = (g == 0) && !reset;
            done[1] = (g == 1) && !reset;
        end
        reset = 1'b0;
        idle();
        repeat (3) step(g);
        chk("pending_reads", 32'(rq0.size() + rq1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (dmem) between the pipeline CPU data port (port 0) and a secondary requester such as a loader or debug engine (port 1). It sits between the CPU/loader and dmem, grants at most one access per cycle, and returns read data one cycle after the grant. It also supports locked bursts with a bounded hold time.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- LOCK_MAX, 8, maximum consecutive locked grants before forced release (≥1)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req0 / req1  input  1  access request, port 0 / port 1
- we0 / we1  input  1  1 = write, 0 = read
- lock0 / lock1  input  1  request to keep ownership after this access
- addr0 / addr1  input  AW  access address
- wdata0 / wdata1  input  DW  write data
- gnt0 / gnt1  output  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  output  1  registered read data valid (1-cycle pulse)
- rdata0 / rdata1  output  DW  registered read data
- mem_we  output  1  dmem write enable
- mem_addr  output  AW  dmem address
- mem_wdata  output  DW  dmem write data
- mem_rdata  input  DW  dmem combinational read data

## Operation
- Handshake: a requester holds req, we, lock, addr and wdata stable until it sees gnt. The transaction completes on the rising edge where gnt=1.
- At most one of gnt0/gnt1 is high in any cycle. gntN implies reqN.
- Memory side: mem_addr/mem_wdata/mem_we mux from the granted port. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Writes: dmem captures on the grant edge. No rvalid is produced.
- Reads: on the grant edge, rdataN ← mem_rdata and rvalidN=1 for the next cycle only. rdataN holds its value until the next read completes.
- FSM states: FREE, OWN0, OWN1.
  - FREE, one request: grant it.
  - FREE, both requesting: the winner is set by the tie policy (see Configuration).
  - FREE → OWNn on an edge where gntn & lockn.
  - OWNn: only port n may be granted. The other port is denied even if port n is idle.
  - OWNn → FREE on an edge where !(reqn & lockn), or where lock_cnt reaches LOCK_MAX.
  - On a forced release with the other port requesting, the other port wins the next cycle regardless of the tie policy.
- lock_cnt counts granted cycles while in OWNn (including the entering grant). It clears in FREE.
- last_gnt register records the most recently granted port.

## Timing
- Grant latency: 0 cycles. gnt is combinational from req and state.
- Read data latency: 1 cycle after the grant edge.
- Back-to-back grants to the same or alternating ports are allowed every cycle. Throughput is 1 access/cycle.
- Reset values: state=FREE, last_gnt=1 (port 0 wins the first tie), lock_cnt=0, rvalid0/1=0, rdata0/1=0. gnt and mem_* follow from the reset state and inputs.
- Reset asserted mid-burst: returns to FREE on that edge. Any rvalid due the following cycle is suppressed.
- Simultaneous events:
  - A lock request from a port denied in FREE has no effect.
  - A read and a write in the same cycle from different ports cannot occur, because only one port is granted.
- LOCK_MAX boundary: a port holding lock continuously receives exactly LOCK_MAX consecutive grants. The state is FREE in the following cycle.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin tie policy. In FREE with both requesting, grant the port ≠ last_gnt.
- DMEM_ARB_RR_EN undefined: fixed priority. In FREE with both requesting, port 0 always wins. last_gnt is still maintained but is unused for arbitration.
- Locking and forced release behave identically in both builds.

## Test plan
- Reset, then req0 read addr=0x10 (mem holds 0x5A) → gnt0=1 the same cycle; next cycle rvalid0=1, rdata0=0x5A; rvalid1=0 throughout.
- req1 write addr=0x20 data=0xC3, then req0 read 0x20 → mem_we=1 only in the port-1 grant cycle; rdata0=0xC3 one cycle after gnt0.
- Both ports request reads continuously for 4 cycles → with DMEM_ARB_RR_EN, grants go 0,1,0,1. Without it, grants go 0,0,0,0 and gnt1 stays 0.
- Port 1 holds req1 & lock1 with LOCK_MAX=8 while req0 is held → gnt1 for exactly 8 cycles, gnt0 in cycle 9, state FREE.
- Port 0 enters OWN0 and then drops req0 for 1 cycle while req1 is high → gnt1=0 in the cycle of the drop (still OWN0); FREE on that edge; gnt1=1 the next cycle.
- reset asserted the cycle after a granted read → rvalid0=0 the next cycle, rdata0=0, state FREE.
